// File: rtl/prog_loader.sv
// Boot loader: assembles UART bytes into 12-bit words and writes them sequentially into program memory.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the last word.
module prog_loader #(
  parameter int AW = 9,
  parameter int DW = 12,
  parameter logic [AW-1:0] START_ADDR = {AW{1'b0}}
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_data,
  output logic          cpu_rstn,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CNT_LO  = 3'd1;
  localparam logic [2:0] S_DATA_HI = 3'd2;
  localparam logic [2:0] S_DATA_LO = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK   = 3'd4;
  localparam logic [2:0] S_LAST    = S_CHECK;
`else
  localparam logic [2:0] S_LAST    = S_DONE;
`endif

  logic [2:0] state_r;
  logic [1:0] cnt_hi_r;
  logic [3:0] nib_r;
  logic [9:0] remaining_r;
  logic [9:0] count_s;
  logic       count_ok_s;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum_r;

  function automatic logic [7:0] csum_upd(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  assign count_s    = {cnt_hi_r, rx_data};
  assign count_ok_s = (count_s != 10'd0) && (count_s <= 10'd512);

  // Frame-parsing FSM and all registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= S_IDLE;
      cnt_hi_r    <= 2'd0;
      nib_r       <= 4'd0;
      remaining_r <= 10'd0;
      mem_addr    <= START_ADDR;
      mem_wr      <= 1'b0;
      mem_data    <= {DW{1'b0}};
      cpu_rstn    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_r      <= 8'd0;
`endif
    end else begin
      mem_wr <= 1'b0;
      // Address advances only once the strobed write has been presented
      if (mem_wr) begin
        mem_addr <= mem_addr + AW'(1);
      end
      case (state_r)
        S_IDLE, S_DONE: begin
          if (rx_valid) begin
            cnt_hi_r <= rx_data[1:0];
            cpu_rstn <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
            mem_addr <= START_ADDR;
            state_r  <= S_CNT_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_r   <= rx_data;
`endif
          end else if (state_r == S_DONE && mem_wr) begin
            // Release the CPU only after the final word has been written
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_rstn <= 1'b1;
          end
        end
        S_CNT_LO: begin
          if (rx_valid) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_r <= csum_upd(csum_r, rx_data);
`endif
            if (count_ok_s) begin
              remaining_r <= count_s;
              state_r     <= S_DATA_HI;
            end else begin
              err     <= 1'b1;
              busy    <= 1'b0;
              state_r <= S_ERR;
            end
          end
        end
        S_DATA_HI: begin
          if (rx_valid) begin
            nib_r   <= rx_data[3:0];
            state_r <= S_DATA_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_r  <= csum_upd(csum_r, rx_data);
`endif
          end
        end
        S_DATA_LO: begin
          if (rx_valid) begin
            mem_data    <= {nib_r, rx_data};
            mem_wr      <= 1'b1;
            remaining_r <= remaining_r - 10'd1;
            state_r     <= (remaining_r == 10'd1) ? S_LAST : S_DATA_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_r      <= csum_upd(csum_r, rx_data);
`endif
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (rx_valid) begin
            if (rx_data == csum_r) begin
              done     <= 1'b1;
              busy     <= 1'b0;
              cpu_rstn <= 1'b1;
              state_r  <= S_DONE;
            end else begin
              err     <= 1'b1;
              busy    <= 1'b0;
              state_r <= S_ERR;
            end
          end
        end
`endif
        S_ERR: begin
          err      <= 1'b1;
          busy     <= 1'b0;
          cpu_rstn <= 1'b0;
        end
        default: begin
          err      <= 1'b1;
          busy     <= 1'b0;
          cpu_rstn <= 1'b0;
          state_r  <= S_ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued by the driver and matched by a monitor.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic [8:0]  mem_addr;
  logic        mem_wr;
  logic [11:0] mem_data;
  logic        cpu_rstn, busy, done, err;

  typedef struct {
    logic [8:0]  a;
    logic [11:0] d;
    int          c;
  } exp_t;

  exp_t       exp_q[$];
  int         ncmp = 0;
  int         nfail = 0;
  int         cyc = 0;
  logic [7:0] tb_x = 8'd0;

  prog_loader dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_data(mem_data),
    .cpu_rstn(cpu_rstn), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (mem_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write (t=%0t)", mem_addr, mem_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.a));
        chk("wr_data", 32'(mem_data), 32'(e.d));
        chk("wr_cycle", cyc, e.c);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    tb_x     = tb_x ^ b;
  endtask

  task automatic send_word(input logic [11:0] w, input logic [8:0] a, input logic [3:0] pad, input bit wr_exp);
    exp_t e;
    send_byte({pad, w[11:8]});
    @(negedge clk);
    rx_data  = w[7:0];
    rx_valid = 1'b1;
    tb_x     = tb_x ^ w[7:0];
    if (wr_exp) begin
      e.a = a; e.d = w; e.c = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_frame(input logic [7:0] hi, input logic [7:0] lo);
    tb_x = 8'd0;
    send_byte(hi);
    send_byte(lo);
  endtask

  task automatic end_frame();
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(tb_x);
`endif
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_status(input string nm, input logic b, input logic d, input logic e, input logic c);
    chk({nm, "_busy"}, 32'(busy), 32'(b));
    chk({nm, "_done"}, 32'(done), 32'(d));
    chk({nm, "_err"}, 32'(err), 32'(e));
    chk({nm, "_cpu_rstn"}, 32'(cpu_rstn), 32'(c));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(mem_data), 32'd0);
    chk("rst_wr", 32'(mem_wr), 32'd0);
    chk_status("rst", 1'b0, 1'b0, 1'b0, 1'b1);
    rstn = 1'b1;
    @(negedge clk);

    // Reset asserted mid-frame after one word has been written
    start_frame(8'h00, 8'h03);
    send_word(12'h206, 9'd0, 4'h0, 1'b1);
    send_byte(8'h04);
    @(negedge clk);
    rx_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("midrst_addr", 32'(mem_addr), 32'd0);
    chk("midrst_data", 32'(mem_data), 32'd0);
    chk("midrst_wr", 32'(mem_wr), 32'd0);
    chk_status("midrst", 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Three-word frame, back-to-back bytes 00 03 02 06 04 07 07 00
    start_frame(8'h00, 8'h03);
    chk_status("load3_busy", 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(12'h206, 9'd0, 4'h0, 1'b1);
    send_word(12'h407, 9'd1, 4'h0, 1'b1);
    send_word(12'h700, 9'd2, 4'h0, 1'b1);
    end_frame();
    idle(4);
    chk_status("load3_end", 1'b0, 1'b1, 1'b0, 1'b1);

    // Reload after DONE: 00 01 0F FF
    start_frame(8'h00, 8'h01);
    chk_status("reload_start", 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(12'hFFF, 9'd0, 4'h0, 1'b1);
    end_frame();
    idle(4);
    chk_status("reload_end", 1'b0, 1'b1, 1'b0, 1'b1);

    // 512-word frame; ignored upper bits set in CNT_HI and HI bytes
    start_frame(8'hFE, 8'h00);
    for (int i = 0; i < 512; i++) begin
      logic [11:0] w;
      w = 12'((i * 37 + 5) & 12'hFFF);
      send_word(w, 9'(i), 4'hA, 1'b1);
    end
    end_frame();
    idle(4);
    chk("full_final_addr", 32'(mem_addr), 32'd0);
    chk_status("full_end", 1'b0, 1'b1, 1'b0, 1'b1);

    // Count 0 is illegal; subsequent bytes are ignored
    start_frame(8'h00, 8'h00);
    idle(2);
    chk_status("cnt0", 1'b0, 1'b0, 1'b1, 1'b0);
    send_byte(8'h02);
    send_byte(8'h06);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(12'h123, 9'd0, 4'h0, 1'b0);
    idle(3);
    chk_status("cnt0_sticky", 1'b0, 1'b0, 1'b1, 1'b0);

    // Count 513 is illegal; reset clears the sticky error
    pulse_reset();
    chk("err_cleared", 32'(err), 32'd0);
    start_frame(8'h02, 8'h01);
    idle(2);
    chk_status("cnt513", 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_reset();

`ifdef PROG_LOADER_CHECKSUM_EN
    // Good trailer: XOR of 00 01 01 23
    start_frame(8'h00, 8'h01);
    send_word(12'h123, 9'd0, 4'h0, 1'b1);
    send_byte(8'h23);
    idle(3);
    chk_status("csum_ok", 1'b0, 1'b1, 1'b0, 1'b1);
    // Bad trailer: word still written, frame fails
    start_frame(8'h00, 8'h01);
    send_word(12'h123, 9'd0, 4'h0, 1'b1);
    send_byte(8'h00);
    idle(3);
    chk_status("csum_bad", 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    idle(3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
